rgb_channel_ctrl: RTL

//  Shares one quadrature encoder plus push button between the three colour channels of the mixer.

---
 rtl/rgb_channel_ctrl_if.sv | 24 ++
 rtl/rgb_channel_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rgb_channel_ctrl_if.sv
// Encoder/button inputs and PWM level outputs shared between the
// encoder front end and the RGB channel controller.
interface rgb_channel_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             inc;
   logic             dec;
   logic             sel;
   logic [WIDTH-1:0] level0;
   logic [WIDTH-1:0] level1;
   logic [WIDTH-1:0] level2;
   logic [1:0]       chan;
   logic             fading;

   modport master (
      output inc, dec, sel,
      input  level0, level1, level2, chan, fading
   );

   modport slave (
      input  inc, dec, sel,
      output level0, level1, level2, chan, fading
   );
endinterface

// File: rtl/rgb_channel_ctrl.sv
// Three-channel PWM level editor: one encoder edits the selected channel,
// the button cycles EDIT0 -> EDIT1 -> EDIT2 -> FADE, FADE bounces all levels.
module rgb_channel_ctrl #(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int TICK_DIV = 1024
) (
   input logic               clk,
   input logic               reset_n,
   rgb_channel_ctrl_if.slave bus
);
   localparam int SW = WIDTH + 2;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic signed [SW-1:0] LMAX      = SW'((2 ** WIDTH) - 1);
   localparam logic signed [SW-1:0] STEP_S    = SW'(STEP);
   localparam logic [WIDTH-1:0]     LMAX_U    = {WIDTH{1'b1}};
   localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      EDIT0 = 2'd0,
      EDIT1 = 2'd1,
      EDIT2 = 2'd2,
      FADE  = 2'd3
   } state_t;

   // Result layout {hit, level}: hit means the clamp engaged (fade reverses direction).
   function automatic logic [WIDTH:0] clamp_up(input logic [WIDTH-1:0] lvl,
                                               input logic signed [SW-1:0] amt);
      logic signed [SW-1:0] s;
      s = $signed({2'b00, lvl}) + amt;
      if (s >= LMAX) clamp_up = {1'b1, LMAX_U};
      else           clamp_up = {1'b0, s[WIDTH-1:0]};
   endfunction

   function automatic logic [WIDTH:0] clamp_dn(input logic [WIDTH-1:0] lvl,
                                               input logic signed [SW-1:0] amt);
      logic signed [SW-1:0] l;
      logic signed [SW-1:0] s;
      l = $signed({2'b00, lvl});
      s = l - amt;
      if (l <= amt) clamp_dn = {1'b1, {WIDTH{1'b0}}};
      else          clamp_dn = {1'b0, s[WIDTH-1:0]};
   endfunction

   state_t                  state, state_nxt;
   logic [TW-1:0]           tick_p0;
   logic [2:0][WIDTH-1:0]   lvl_p0, lvl_nxt;
   logic [2:0]              dir_p0, dir_nxt;
   logic                    fading_p0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= EDIT0;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.sel) begin
         case (state)
            EDIT0:   state_nxt = EDIT1;
            EDIT1:   state_nxt = EDIT2;
            EDIT2:   state_nxt = FADE;
            default: state_nxt = EDIT0;
         endcase
      end
   end

   // tick only runs while fading; any sel or non-FADE state parks it at 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tick_p0 <= '0;
      else if (bus.sel || state != FADE || tick_p0 == TICK_LAST)
         tick_p0 <= '0;
      else
         tick_p0 <= tick_p0 + 1'b1;
   end

   always_comb begin
      logic [WIDTH:0] r;
      r       = '0;
      lvl_nxt = lvl_p0;
      dir_nxt = dir_p0;
      if (bus.sel) begin
         if (state == EDIT2) dir_nxt = '1;
      end else if (state == FADE) begin
         if (tick_p0 == TICK_LAST) begin
            for (int k = 0; k < 3; k++) begin
               if (dir_p0[k]) r = clamp_up(lvl_p0[k], SW'((k + 1) * STEP));
               else           r = clamp_dn(lvl_p0[k], SW'((k + 1) * STEP));
               lvl_nxt[k] = r[WIDTH-1:0];
               if (r[WIDTH]) dir_nxt[k] = ~dir_p0[k];
            end
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (state == state_t'(k)) begin
               if (bus.inc && !bus.dec) begin
                  r = clamp_up(lvl_p0[k], STEP_S);
                  lvl_nxt[k] = r[WIDTH-1:0];
               end else if (bus.dec && !bus.inc) begin
                  r = clamp_dn(lvl_p0[k], STEP_S);
                  lvl_nxt[k] = r[WIDTH-1:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lvl_p0    <= '0;
         dir_p0    <= '1;
         fading_p0 <= 1'b0;
      end else begin
         lvl_p0    <= lvl_nxt;
         dir_p0    <= dir_nxt;
         fading_p0 <= (state_nxt == FADE);
      end
   end

   assign bus.level0 = lvl_p0[0];
   assign bus.level1 = lvl_p0[1];
   assign bus.level2 = lvl_p0[2];
   assign bus.chan   = state;
   assign bus.fading = fading_p0;
endmodule
